// File: rtl/mem_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_if
// Data-memory request/acknowledge bus between the MEM-stage controller and the
// data memory.
//   mem_req   : request, held high until acknowledged or timed out
//   mem_we    : 1 = write, 0 = read; valid while mem_req = 1
//   mem_addr  : word address
//   mem_wdata : store data
//   mem_rdata : load data, valid with mem_ack
//   mem_ack   : single-cycle completion strobe
// master = MEM-stage controller, slave = data memory.
// -----------------------------------------------------------------------------
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage controller of the 5-stage ARM pipeline. Non-memory instructions
// pass to the MEM/WB register with one cycle of latency. LDR/STR that pass the
// alignment/range checks run a request/acknowledge access on the data-memory
// bus while freezing the upstream pipeline; faulted or timed-out accesses
// raise a one-cycle err pulse and suppress writeback.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   mem_read        : EX instruction is LDR
//   mem_write       : EX instruction is STR
//   wb_en_in        : EX writeback enable
//   dest_in         : EX destination register
//   alu_result      : byte address (memory ops) or ALU result
//   val_rm          : store data
//   mem             : data-memory bus (master side)
//   freeze          : holds the IF/ID/EX pipeline registers
//   wb_en_out       : MEM/WB writeback enable
//   mem_read_out    : MEM/WB selects mem_data_out as writeback value
//   dest_out        : MEM/WB destination register
//   alu_result_out  : MEM/WB ALU result
//   mem_data_out    : MEM/WB load data
//   err             : one-cycle pulse on a faulted or timed-out access
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic                   wb_en_in,
    input  logic [3:0]             dest_in,
    input  logic [31:0]            alu_result,
    input  logic [31:0]            val_rm,
    mem_stage_ctrl_if.master       mem,
    output logic                   freeze,
    output logic                   wb_en_out,
    output logic                   mem_read_out,
    output logic [3:0]             dest_out,
    output logic [31:0]            alu_result_out,
    output logic [31:0]            mem_data_out,
    output logic                   err
);

    localparam logic [31:0] BASE_C  = ADDR_BASE;
    localparam logic [31:0] LIMIT_C = DEPTH_WORDS * 4;
    localparam int          CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Request held on the bus while in REQ.
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    // Instruction bundle captured at request start, presented in DONE.
    logic             cap_wb_q, cap_wb_d;
    logic [3:0]       cap_dest_q, cap_dest_d;
    logic [31:0]      cap_alu_q, cap_alu_d;

    // MEM/WB output register.
    logic             wb_q, wb_d;
    logic             rd_q, rd_d;
    logic             err_q, err_d;
    logic [3:0]       dest_q, dest_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      data_q, data_d;

    logic [31:0]      off;
    logic             is_mem;
    logic             fault;
    logic             start;

    // Unsigned compare of the wrapped offset also rejects addresses below base.
    assign off    = alu_result - BASE_C;
    assign is_mem = mem_read | mem_write;
    assign fault  = (alu_result[1:0] != 2'b00) | (off >= LIMIT_C) | (mem_read & mem_write);
    assign start  = (state_q == S_IDLE) & is_mem & ~fault;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cap_wb_d   = cap_wb_q;
        cap_dest_d = cap_dest_q;
        cap_alu_d  = cap_alu_q;
        wb_d       = 1'b0;
        rd_d       = 1'b0;
        err_d      = 1'b0;
        dest_d     = dest_q;
        alu_d      = alu_q;
        data_d     = data_q;

        unique case (state_q)
            S_IDLE: begin
                if (!is_mem) begin
                    wb_d   = wb_en_in;
                    dest_d = dest_in;
                    alu_d  = alu_result;
                end else if (fault) begin
                    err_d  = 1'b1;
                    dest_d = dest_in;
                    alu_d  = alu_result;
                end else begin
                    state_d    = S_REQ;
                    cnt_d      = '0;
                    we_d       = mem_write;
                    addr_d     = {2'b00, off[31:2]};
                    wdata_d    = val_rm;
                    cap_wb_d   = wb_en_in;
                    cap_dest_d = dest_in;
                    cap_alu_d  = alu_result;
                end
            end

            S_REQ: begin
                // An ack in the final counted cycle takes priority over timeout.
                if (mem.mem_ack) begin
                    state_d = S_DONE;
                    wb_d    = cap_wb_q & ~we_q;
                    rd_d    = ~we_q;
                    dest_d  = cap_dest_q;
                    alu_d   = cap_alu_q;
                    if (!we_q) begin
                        data_d = mem.mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rd_d    = ~we_q;
                    dest_d  = cap_dest_q;
                    alu_d   = cap_alu_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // EX still holds the finished instruction here; it is ignored.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; all registers here are small flops, so every one is
    // reset and no output can show stale data after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_wb_q   <= 1'b0;
            cap_dest_q <= '0;
            cap_alu_q  <= '0;
            wb_q       <= 1'b0;
            rd_q       <= 1'b0;
            err_q      <= 1'b0;
            dest_q     <= '0;
            alu_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cap_wb_q   <= cap_wb_d;
            cap_dest_q <= cap_dest_d;
            cap_alu_q  <= cap_alu_d;
            wb_q       <= wb_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            dest_q     <= dest_d;
            alu_q      <= alu_d;
            data_q     <= data_d;
        end
    end

    // mem_req follows the asynchronously reset state, so it drops with rst.
    assign mem.mem_req   = (state_q == S_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Freeze starts combinationally in the IDLE cycle that launches a request;
    // gated by rst because the EX inputs may still show a memory op.
    assign freeze = ~rst & (start | (state_q == S_REQ));

    assign wb_en_out      = wb_q;
    assign mem_read_out   = rd_q;
    assign dest_out       = dest_q;
    assign alu_result_out = alu_q;
    assign mem_data_out   = data_q;
    assign err            = err_q;

endmodule
